// File: rtl/spi_pkg.sv
// Shared encodings and defaults for the SPI request arbiter and its clients.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_BUSY   = 3'd2,
        ST_RESP   = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    localparam logic [9:0]  SPI_CLK_DIV_DEF = 10'd10;
    localparam logic [15:0] SPI_TIMEOUT_DEF = 16'd4095;

    localparam logic SPI_WE_WRITE = 1'b1;
    localparam logic SPI_WE_READ  = 1'b0;

    // Counter value on the third LAUNCH cycle; master sync + done-clear need 3 cycles.
    localparam logic [15:0] LAUNCH_MIN_M1 = 16'd2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; last_grant resets to 1 so requester 0 wins first.
module rr_arb2 (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_take,
    output logic o_valid,
    output logic o_gnt
);

    logic r_last;
    logic w_gnt;

    always_comb begin
        if (i_req0 && i_req1) w_gnt = ~r_last;
        else                  w_gnt = i_req1;
    end

    assign o_valid = i_req0 | i_req1;
    assign o_gnt   = w_gnt;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)                 r_last <= 1'b1;
        else if (i_take && o_valid)  r_last <= w_gnt;
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// Serialises two clients' register requests onto one spi_master, generating
// the start-level handshake, tracking sticky done and aborting on timeout.
module spi_req_arbiter import spi_pkg::*; #(
    parameter logic [9:0]  CLK_DIV = SPI_CLK_DIV_DEF,
    parameter logic [15:0] TIMEOUT = SPI_TIMEOUT_DEF
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_we0,
    input  logic       i_we1,
    input  logic [7:0] i_addr0,
    input  logic [7:0] i_addr1,
    input  logic [7:0] i_wdata0,
    input  logic [7:0] i_wdata1,
    output logic       o_ack0,
    output logic       o_ack1,
    output logic [7:0] o_rdata,
    output logic       o_err,
    output logic       o_busy,
    output logic [9:0] o_spi_freq,
    output logic [7:0] o_spi_addr,
    output logic [7:0] o_spi_wdata,
    output logic       o_spi_start_wr,
    output logic       o_spi_start_re,
    input  logic [7:0] i_spi_rdata,
    input  logic       i_spi_done
);

    state_t      r_state, w_next;
    logic [15:0] r_tmo;
    logic        r_we, r_id, r_err, r_gap;
    logic [7:0]  r_addr, r_wdata, r_rdata;
    logic        w_grant, w_req_any, w_gnt_id, w_tmo_hit;
    logic        w_sel_we;
    logic [7:0]  w_sel_addr, w_sel_wdata;

    rr_arb2 u_arb (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_req0  (i_req0),
        .i_req1  (i_req1),
        .i_take  (w_grant),
        .o_valid (w_req_any),
        .o_gnt   (w_gnt_id)
    );

    assign w_sel_we    = w_gnt_id ? i_we1    : i_we0;
    assign w_sel_addr  = w_gnt_id ? i_addr1  : i_addr0;
    assign w_sel_wdata = w_gnt_id ? i_wdata1 : i_wdata0;
    assign w_tmo_hit   = (r_tmo == TIMEOUT);

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        case (r_state)
            ST_IDLE: if (w_req_any) begin
                w_grant = 1'b1;
                w_next  = ST_LAUNCH;
            end
            // Timeout outranks the normal exit in both LAUNCH and BUSY.
            ST_LAUNCH: begin
                if (w_tmo_hit)                                    w_next = ST_RESP;
                else if (r_tmo >= LAUNCH_MIN_M1 && !i_spi_done)   w_next = ST_BUSY;
            end
            ST_BUSY: if (w_tmo_hit || i_spi_done) w_next = ST_RESP;
            ST_RESP: w_next = ST_GAP;
            ST_GAP:  if (r_gap) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_tmo   <= 16'd0;
            r_we    <= SPI_WE_READ;
            r_id    <= 1'b0;
            r_err   <= 1'b0;
            r_gap   <= 1'b0;
            r_addr  <= 8'd0;
            r_wdata <= 8'd0;
            r_rdata <= 8'd0;
        end else begin
            r_state <= w_next;
            r_gap   <= (r_state == ST_GAP);
            if (w_grant) begin
                r_id    <= w_gnt_id;
                r_we    <= w_sel_we;
                r_addr  <= w_sel_addr;
                r_wdata <= (w_sel_we == SPI_WE_WRITE) ? w_sel_wdata : 8'd0;
                r_tmo   <= 16'd0;
            end else if (r_state == ST_LAUNCH || r_state == ST_BUSY) begin
                r_tmo <= r_tmo + 16'd1;
            end
            // Capture on entry so data and err are already valid in the ack cycle.
            if (w_next == ST_RESP && r_state != ST_RESP) begin
                r_err <= w_tmo_hit;
                if (r_we == SPI_WE_READ) r_rdata <= i_spi_rdata;
            end
        end
    end

    assign o_busy         = (r_state != ST_IDLE);
    assign o_spi_start_wr = (r_state == ST_LAUNCH) && (r_we == SPI_WE_WRITE);
    assign o_spi_start_re = (r_state == ST_LAUNCH) && (r_we == SPI_WE_READ);
    assign o_ack0         = (r_state == ST_RESP) && !r_id;
    assign o_ack1         = (r_state == ST_RESP) &&  r_id;
    assign o_err          = (r_state == ST_RESP) && r_err;
    assign o_rdata        = r_rdata;
    assign o_spi_addr     = r_addr;
    assign o_spi_wdata    = r_wdata;
    assign o_spi_freq     = CLK_DIV;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Randomised and directed bench for spi_req_arbiter with a behavioural SPI master stand-in.
module tb_spi_req_arbiter;

    localparam logic [15:0] TMO = 16'd200;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       ack0, ack1, err, busy, start_wr, start_re;
    logic [7:0] rdata, spi_addr, spi_wdata;
    logic [9:0] spi_freq;
    logic [7:0] spi_rdata;
    logic       spi_done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    spi_req_arbiter #(.CLK_DIV(10'd10), .TIMEOUT(TMO)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_ack0(ack0), .o_ack1(ack1), .o_rdata(rdata), .o_err(err), .o_busy(busy),
        .o_spi_freq(spi_freq), .o_spi_addr(spi_addr), .o_spi_wdata(spi_wdata),
        .o_spi_start_wr(start_wr), .o_spi_start_re(start_re),
        .i_spi_rdata(spi_rdata), .i_spi_done(spi_done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Stand-in for spi_master: 2-flop start sync, edge detect, sticky done, MOSI frame log.
    logic [7:0] slave_mem [256];
    logic [7:0] mosi_q [$];
    logic [2:0] wr_sy, re_sy;
    bit         m_act, m_rd, force_hang;
    int         m_wait, edges;
    logic [7:0] m_a;
    wire        m_nrst = ~rst;

    always @(posedge clk or negedge m_nrst) begin
        if (!m_nrst) begin
            wr_sy <= 3'd0; re_sy <= 3'd0; m_act <= 1'b0; m_rd <= 1'b0; m_wait <= 0;
            m_a <= 8'd0; spi_done <= 1'b0; spi_rdata <= 8'd0; edges <= 0;
        end else begin
            wr_sy <= {wr_sy[1:0], start_wr};
            re_sy <= {re_sy[1:0], start_re};
            if (!m_act && ((wr_sy[1] && !wr_sy[2]) || (re_sy[1] && !re_sy[2]))) begin
                edges    <= edges + 1;
                spi_done <= 1'b0;
                m_act    <= !force_hang;
                m_rd     <= re_sy[1];
                m_a      <= spi_addr;
                m_wait   <= $urandom_range(20, 60);
                if (re_sy[1]) begin
                    mosi_q.push_back(8'h00); mosi_q.push_back(spi_addr);
                end else begin
                    mosi_q.push_back(8'hFF); mosi_q.push_back(spi_addr); mosi_q.push_back(spi_wdata);
                end
            end else if (m_act) begin
                if (m_wait == 0) begin
                    m_act    <= 1'b0;
                    spi_done <= 1'b1;
                    if (m_rd) spi_rdata <= slave_mem[m_a];
                end else begin
                    m_wait <= m_wait - 1;
                end
            end
        end
    end

    // Reference model: phase 0 idle, 1 launch, 2 busy, 3 resp, 4/5 gap; age = cycles spent on the transaction.
    int         mp, m_age;
    bit         m_last, m_id, m_we, m_err;
    logic [7:0] m_addr, m_wdata, m_rdata;
    wire        m_pick = (req0 && req1) ? !m_last : req1;
    wire        m_pwe  = m_pick ? we1 : we0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mp <= 0; m_age <= 0; m_last <= 1'b1; m_id <= 1'b0; m_we <= 1'b0; m_err <= 1'b0;
            m_addr <= 8'd0; m_wdata <= 8'd0; m_rdata <= 8'd0;
        end else begin
            case (mp)
                0: if (req0 || req1) begin
                    m_last  <= m_pick;
                    m_id    <= m_pick;
                    m_we    <= m_pwe;
                    m_addr  <= m_pick ? addr1 : addr0;
                    m_wdata <= m_pwe ? (m_pick ? wdata1 : wdata0) : 8'd0;
                    m_age   <= 0;
                    mp      <= 1;
                end
                1, 2: begin
                    m_age <= m_age + 1;
                    if (m_age == int'(TMO) || (mp == 2 && spi_done)) begin
                        mp    <= 3;
                        m_err <= (m_age == int'(TMO));
                        if (!m_we) m_rdata <= spi_rdata;
                    end else if (mp == 1 && m_age + 1 >= 3 && !spi_done) begin
                        mp <= 2;
                    end
                end
                3: mp <= 4;
                4: mp <= 5;
                default: mp <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("busy",      busy,      mp != 0);
        chk("start_wr",  start_wr,  mp == 1 && m_we);
        chk("start_re",  start_re,  mp == 1 && !m_we);
        chk("ack0",      ack0,      mp == 3 && !m_id);
        chk("ack1",      ack1,      mp == 3 && m_id);
        chk("err",       err,       mp == 3 && m_err);
        chk("rdata",     rdata,     m_rdata);
        chk("spi_addr",  spi_addr,  m_addr);
        chk("spi_wdata", spi_wdata, m_wdata);
        chk("spi_freq",  spi_freq,  10);
    end

    int cyc = 0, sw_cnt = 0, a0 = 0, a1 = 0;

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (start_wr) sw_cnt++;
        if (ack0) a0++;
        if (ack1) a1++;
    endtask

    task automatic wait_ack(output int id, output int t, input int budget);
        id = -1; t = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (ack0 || ack1) begin
                id = ack1 ? 1 : 0; t = cyc;
                return;
            end
        end
        vectors++; miscompares++;
        $display("FAIL ack_wait: no ack within %0d cycles", budget);
    endtask

    task automatic chk_frame(input string nm, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input int n);
        logic [7:0] exp [3];
        exp[0] = b0; exp[1] = b1; exp[2] = b2;
        chk({nm, "_len"}, mosi_q.size(), n);
        for (int i = 0; i < n && i < mosi_q.size(); i++) chk({nm, "_byte"}, mosi_q[i], exp[i]);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int id, t, t0, snap0, snap1, acks, cnt;
        int ord [4];
        int tm [4];
        bit seen;
        for (int i = 0; i < 256; i++) slave_mem[i] = 8'($urandom_range(0, 255));
        slave_mem[8'h34] = 8'h5C;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        force_hang = 0;
        #1 rst = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_acks", {ack0, ack1, err}, 0);
        chk("rst_starts", {start_wr, start_re}, 0);
        chk("rst_freq", spi_freq, 10'd10);
        chk("rst_rdata", rdata, 0);
        rst = 1'b0;
        tick();

        // Single write, also the first transaction after reset (start hold).
        sw_cnt = 0; a0 = 0; a1 = 0; mosi_q.delete();
        req0 = 1; we0 = 1; addr0 = 8'h12; wdata0 = 8'hA5;
        wait_ack(id, t, 300);
        req0 = 0;
        chk("wr_ack_id", id, 0);
        chk("wr_err", err, 0);
        chk("wr_start_cycles", sw_cnt, 3);
        chk("wr_start_edges", edges, 1);
        chk_frame("wr_frame", 8'hFF, 8'h12, 8'hA5, 3);
        repeat (5) tick();
        chk("wr_ack0_count", a0, 1);
        chk("wr_ack1_none", a1, 0);

        // Single read.
        mosi_q.delete();
        req1 = 1; we1 = 0; addr1 = 8'h34;
        wait_ack(id, t, 300);
        req1 = 0;
        chk("rd_ack_id", id, 1);
        chk("rd_rdata", rdata, 8'h5C);
        chk("rd_err", err, 0);
        chk_frame("rd_frame", 8'h00, 8'h34, 8'h00, 2);
        repeat (100) tick();
        chk("rd_rdata_held", rdata, 8'h5C);

        // Contention: both held for four transactions.
        req0 = 1; req1 = 1;
        we0 = $urandom_range(0, 1) != 0; addr0 = 8'($urandom_range(0, 255)); wdata0 = 8'($urandom_range(0, 255));
        we1 = $urandom_range(0, 1) != 0; addr1 = 8'($urandom_range(0, 255)); wdata1 = 8'($urandom_range(0, 255));
        for (int k = 0; k < 4; k++) begin
            wait_ack(id, t, 400);
            ord[k] = id; tm[k] = t;
            if (id == 0) begin
                we0 = $urandom_range(0, 1) != 0; addr0 = 8'($urandom_range(0, 255));
            end else begin
                we1 = $urandom_range(0, 1) != 0; addr1 = 8'($urandom_range(0, 255));
            end
        end
        req0 = 0; req1 = 0;
        for (int k = 0; k < 4; k++) chk("rr_order", ord[k], k % 2);
        for (int k = 1; k < 4; k++) chk("rr_ack_spacing", (tm[k] - tm[k-1]) >= 3, 1);
        repeat (4) tick();

        // Timeout: master accepts the start but never raises done.
        force_hang = 1;
        req0 = 1; we0 = 0; addr0 = 8'($urandom_range(0, 255));
        seen = 0; t0 = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (start_re) begin seen = 1; t0 = cyc; end
        end
        chk("tmo_launch_seen", seen, 1);
        wait_ack(id, t, 400);
        req0 = 0;
        chk("tmo_latency", t - t0, 201);
        chk("tmo_err", err, 1);
        chk("tmo_starts_low", {start_wr, start_re}, 0);
        repeat (3) tick();
        chk("tmo_idle_after_3", busy, 0);
        force_hang = 0;

        // Reset while BUSY.
        req0 = 1; we0 = 1; addr0 = 8'h5A; wdata0 = 8'h3C;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (busy && !start_wr && !start_re) seen = 1;
        end
        chk("rst_mid_busy_seen", seen, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_starts", {start_wr, start_re}, 0);
        chk("rst_mid_acks", {ack0, ack1}, 0);
        req0 = 0;
        snap0 = a0; snap1 = a1;
        tick();
        rst = 1'b0;
        repeat (80) tick();
        chk("rst_mid_no_ack", (a0 - snap0) + (a1 - snap1), 0);
        req0 = 1; we0 = 1; addr0 = 8'h77; wdata0 = 8'h11;
        wait_ack(id, t, 300);
        req0 = 0;
        chk("post_rst_ack_id", id, 0);
        chk("post_rst_err", err, 0);

        // Random traffic; each requester holds until its ack.
        acks = 0; cnt = 0;
        while (cnt < 8000 && acks < 40) begin
            tick();
            cnt++;
            if (ack0) begin req0 = 0; acks++; end
            if (ack1) begin req1 = 0; acks++; end
            if (!req0 && $urandom_range(0, 3) == 0) begin
                req0 = 1; we0 = $urandom_range(0, 1) != 0;
                addr0 = 8'($urandom_range(0, 255)); wdata0 = 8'($urandom_range(0, 255));
            end
            if (!req1 && $urandom_range(0, 3) == 0) begin
                req1 = 1; we1 = $urandom_range(0, 1) != 0;
                addr1 = 8'($urandom_range(0, 255)); wdata1 = 8'($urandom_range(0, 255));
            end
        end
        chk("rand_progress", acks >= 40, 1);
        req0 = 0; req1 = 0;
        repeat (150) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
